// File: rtl/rx_div_cfg_if.sv
// Register-file / RX-divider bundle around the prescale-change controller.
// Handshake: a request is taken on any clk edge where cfg_valid=1 and cfg_ready=1;
// cfg_valid while cfg_ready=0 is dropped, and completion is reported by a one-cycle cfg_ack or cfg_err.
interface rx_div_cfg_if #(
  parameter int DATA_WIDTH = 8
);
  logic [5:0]            cfg_prescale;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic                  cfg_ack;
  logic                  cfg_err;
  logic                  rx_busy;
  logic                  tx_busy;
  logic                  div_tick;
  logic                  div_en;
  logic [DATA_WIDTH-1:0] div_ratio_rx;
  logic [5:0]            active_prescale;

  modport master (
    output cfg_prescale, cfg_valid, rx_busy, tx_busy, div_tick,
    input  cfg_ready, cfg_ack, cfg_err, div_en, div_ratio_rx, active_prescale
  );

  modport slave (
    input  cfg_prescale, cfg_valid, rx_busy, tx_busy, div_tick,
    output cfg_ready, cfg_ack, cfg_err, div_en, div_ratio_rx, active_prescale
  );
endinterface

// File: rtl/rx_div_cfg_ctrl.sv
// Sequences run-time UART RX prescale changes: validate, wait for idle UART and a
// divider period boundary, gate the divider, load the new ratio, re-enable.
module rx_div_cfg_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int GATE_CYCLES  = 2,
  parameter int WAIT_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  rx_div_cfg_if.slave bus,
  output logic [1:0] state_o
);
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_IDLE = 2'd1;
  localparam logic [1:0] S_WAIT_TICK = 2'd2;
  localparam logic [1:0] S_GATE      = 2'd3;

  localparam int CW = $clog2(WAIT_TIMEOUT + 1);
  localparam int GW = $clog2(GATE_CYCLES + 1);

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [GW-1:0]         gcnt_q, gcnt_d;
  logic [5:0]            pend_q, pend_d;
  logic [5:0]            active_q, active_d;
  logic [DATA_WIDTH-1:0] ratio_q, ratio_d;
  logic                  ready_q, ready_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  en_q, en_d;
  logic                  busy;
  logic                  legal;

  function automatic logic [DATA_WIDTH-1:0] ratio_of(input logic [5:0] p);
    case (p)
      6'd32:   ratio_of = DATA_WIDTH'(1);
      6'd16:   ratio_of = DATA_WIDTH'(2);
      6'd8:    ratio_of = DATA_WIDTH'(4);
      6'd4:    ratio_of = DATA_WIDTH'(8);
      default: ratio_of = '0;
    endcase
  endfunction

  assign busy  = bus.rx_busy | bus.tx_busy;
  assign legal = (bus.cfg_prescale == 6'd32) || (bus.cfg_prescale == 6'd16) ||
                 (bus.cfg_prescale == 6'd8)  || (bus.cfg_prescale == 6'd4);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gcnt_d   = gcnt_q;
    pend_d   = pend_q;
    active_d = active_q;
    ratio_d  = ratio_q;
    ready_d  = ready_q;
    en_d     = en_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cfg_valid && ready_q) begin
          if (!legal) begin
            err_d = 1'b1;
          end else if (bus.cfg_prescale == active_q) begin
            ack_d = 1'b1;
          end else begin
            pend_d  = bus.cfg_prescale;
            ready_d = 1'b0;
            cnt_d   = '0;
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (busy) begin
          cnt_d = cnt_q + 1'b1;
          // Abort on the edge where the busy count reaches the timeout.
          if (cnt_q == CW'(WAIT_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            ready_d = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_WAIT_TICK;
        end
      end
      S_WAIT_TICK: begin
        if (busy) begin
          state_d = S_WAIT_IDLE;
        end else if (bus.div_tick) begin
          en_d    = 1'b0;
          ratio_d = ratio_of(pend_q);
          gcnt_d  = '0;
          state_d = S_GATE;
        end
      end
      default: begin
        if (gcnt_q == GW'(GATE_CYCLES - 1)) begin
          en_d     = 1'b1;
          active_d = pend_q;
          ack_d    = 1'b1;
          ready_d  = 1'b1;
          state_d  = S_IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      gcnt_q   <= '0;
      pend_q   <= 6'd32;
      active_q <= 6'd32;
      ratio_q  <= DATA_WIDTH'(1);
      ready_q  <= 1'b1;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      en_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gcnt_q   <= gcnt_d;
      pend_q   <= pend_d;
      active_q <= active_d;
      ratio_q  <= ratio_d;
      ready_q  <= ready_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      en_q     <= en_d;
    end
  end

  assign bus.cfg_ready       = ready_q;
  assign bus.cfg_ack         = ack_q;
  assign bus.cfg_err         = err_q;
  assign bus.div_en          = en_q;
  assign bus.div_ratio_rx    = ratio_q;
  assign bus.active_prescale = active_q;
  assign state_o             = state_q;
endmodule

// File: tb/tb_rx_div_cfg_ctrl.sv
// Directed bench for rx_div_cfg_ctrl: a vector table of requests plus hand-written
// sequences for busy stalls, timeout abort and reset during the gate window.
module tb_rx_div_cfg_ctrl;
  localparam int GC = 2;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_WIDLE = 2'd1, ST_WTICK = 2'd2, ST_GATE = 2'd3;

  logic       clk, rst;
  logic [5:0] cfg_prescale;
  logic       cfg_valid, rx_busy, tx_busy, div_tick;
  logic [1:0] state_a, state_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] cur_active;
  logic [7:0] cur_ratio;

  typedef struct {
    logic [5:0] ps;
    int         kind;   // 0: illegal -> err, 1: already active -> ack, 2: full change
    logic [7:0] ratio;  // ratio expected after a full change
  } vec_t;
  vec_t vecs[10];

  rx_div_cfg_if #(.DATA_WIDTH(8)) bus_a();
  rx_div_cfg_if #(.DATA_WIDTH(8)) bus_b();

  assign bus_a.cfg_prescale = cfg_prescale;
  assign bus_a.cfg_valid    = cfg_valid;
  assign bus_a.rx_busy      = rx_busy;
  assign bus_a.tx_busy      = tx_busy;
  assign bus_a.div_tick     = div_tick;
  assign bus_b.cfg_prescale = cfg_prescale;
  assign bus_b.cfg_valid    = cfg_valid;
  assign bus_b.rx_busy      = rx_busy;
  assign bus_b.tx_busy      = tx_busy;
  assign bus_b.div_tick     = div_tick;

  rx_div_cfg_ctrl #(.DATA_WIDTH(8), .GATE_CYCLES(GC), .WAIT_TIMEOUT(1024)) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .state_o(state_a)
  );

  rx_div_cfg_ctrl #(.DATA_WIDTH(8), .GATE_CYCLES(GC), .WAIT_TIMEOUT(16)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave), .state_o(state_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    cur_active = 6'd32;
    cur_ratio  = 8'd1;
  endtask

  // Starts in WAIT_TICK at a negedge; fires the tick and walks the gate window.
  task automatic do_gate(input logic [7:0] r, input logic [5:0] a);
    div_tick = 1'b1;
    step();
    div_tick = 1'b0;
    for (int g = 0; g < GC; g++) begin
      chk("gate_en", {31'd0, bus_a.div_en}, 32'd0);
      chk("gate_ratio", {24'd0, bus_a.div_ratio_rx}, {24'd0, r});
      chk("gate_ack", {31'd0, bus_a.cfg_ack}, 32'd0);
      chk("gate_active", {26'd0, bus_a.active_prescale}, {26'd0, cur_active});
      chk("gate_state", {30'd0, state_a}, {30'd0, ST_GATE});
      step();
    end
    chk("exit_en", {31'd0, bus_a.div_en}, 32'd1);
    chk("exit_ack", {31'd0, bus_a.cfg_ack}, 32'd1);
    chk("exit_err", {31'd0, bus_a.cfg_err}, 32'd0);
    chk("exit_ready", {31'd0, bus_a.cfg_ready}, 32'd1);
    chk("exit_active", {26'd0, bus_a.active_prescale}, {26'd0, a});
    chk("exit_ratio", {24'd0, bus_a.div_ratio_rx}, {24'd0, r});
    chk("exit_state", {30'd0, state_a}, {30'd0, ST_IDLE});
    step();
    chk("ack_pulse", {31'd0, bus_a.cfg_ack}, 32'd0);
    cur_active = a;
    cur_ratio  = r;
  endtask

  task automatic do_change(input logic [5:0] ps, input logic [7:0] r);
    cfg_prescale = ps;
    cfg_valid    = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("chg_ready", {31'd0, bus_a.cfg_ready}, 32'd0);
    chk("chg_ack", {31'd0, bus_a.cfg_ack}, 32'd0);
    chk("chg_err", {31'd0, bus_a.cfg_err}, 32'd0);
    step();
    step();
    chk("pre_tick_state", {30'd0, state_a}, {30'd0, ST_WTICK});
    chk("pre_tick_en", {31'd0, bus_a.div_en}, 32'd1);
    chk("pre_tick_ratio", {24'd0, bus_a.div_ratio_rx}, {24'd0, cur_ratio});
    do_gate(r, ps);
  endtask

  task automatic do_imm(input logic [5:0] ps, input int kind);
    cfg_prescale = ps;
    cfg_valid    = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("imm_err", {31'd0, bus_a.cfg_err}, (kind == 0) ? 32'd1 : 32'd0);
    chk("imm_ack", {31'd0, bus_a.cfg_ack}, (kind == 1) ? 32'd1 : 32'd0);
    chk("imm_ready", {31'd0, bus_a.cfg_ready}, 32'd1);
    chk("imm_en", {31'd0, bus_a.div_en}, 32'd1);
    chk("imm_ratio", {24'd0, bus_a.div_ratio_rx}, {24'd0, cur_ratio});
    chk("imm_active", {26'd0, bus_a.active_prescale}, {26'd0, cur_active});
    step();
    chk("imm_err_pulse", {31'd0, bus_a.cfg_err}, 32'd0);
    chk("imm_ack_pulse", {31'd0, bus_a.cfg_ack}, 32'd0);
    chk("imm_en_hold", {31'd0, bus_a.div_en}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{ps: 6'd8,  kind: 2, ratio: 8'd4};
    vecs[1] = '{ps: 6'd12, kind: 0, ratio: 8'd0};
    vecs[2] = '{ps: 6'd8,  kind: 1, ratio: 8'd0};
    vecs[3] = '{ps: 6'd0,  kind: 0, ratio: 8'd0};
    vecs[4] = '{ps: 6'd63, kind: 0, ratio: 8'd0};
    vecs[5] = '{ps: 6'd16, kind: 2, ratio: 8'd2};
    vecs[6] = '{ps: 6'd2,  kind: 0, ratio: 8'd0};
    vecs[7] = '{ps: 6'd32, kind: 2, ratio: 8'd1};
    vecs[8] = '{ps: 6'd32, kind: 1, ratio: 8'd0};
    vecs[9] = '{ps: 6'd48, kind: 0, ratio: 8'd0};

    rst = 1'b1;
    cfg_prescale = 6'd0;
    cfg_valid = 1'b0;
    rx_busy = 1'b0;
    tx_busy = 1'b0;
    div_tick = 1'b0;
    do_reset();

    // Reset values
    chk("rst_ready", {31'd0, bus_a.cfg_ready}, 32'd1);
    chk("rst_ack", {31'd0, bus_a.cfg_ack}, 32'd0);
    chk("rst_err", {31'd0, bus_a.cfg_err}, 32'd0);
    chk("rst_en", {31'd0, bus_a.div_en}, 32'd1);
    chk("rst_ratio", {24'd0, bus_a.div_ratio_rx}, 32'd1);
    chk("rst_active", {26'd0, bus_a.active_prescale}, 32'd32);
    chk("rst_state", {30'd0, state_a}, {30'd0, ST_IDLE});
    chk("rst_b_active", {26'd0, bus_b.active_prescale}, 32'd32);

    // Request table
    foreach (vecs[i]) begin
      if (vecs[i].kind == 2) do_change(vecs[i].ps, vecs[i].ratio);
      else do_imm(vecs[i].ps, vecs[i].kind);
    end

    // Long rx_busy stall, then busy bounces back from WAIT_TICK
    cfg_prescale = 6'd4;
    cfg_valid    = 1'b1;
    rx_busy      = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("busy_ready", {31'd0, bus_a.cfg_ready}, 32'd0);
    for (int i = 0; i < 50; i++) begin
      div_tick = (i % 3 == 0);
      step();
      chk("busy_en", {31'd0, bus_a.div_en}, 32'd1);
      chk("busy_ratio", {24'd0, bus_a.div_ratio_rx}, 32'd1);
    end
    div_tick = 1'b0;
    chk("busy_state", {30'd0, state_a}, {30'd0, ST_WIDLE});
    rx_busy = 1'b0;
    step();
    chk("unbusy_state", {30'd0, state_a}, {30'd0, ST_WTICK});
    rx_busy  = 1'b1;
    div_tick = 1'b1;
    step();
    chk("busy_prio_state", {30'd0, state_a}, {30'd0, ST_WIDLE});
    chk("busy_prio_en", {31'd0, bus_a.div_en}, 32'd1);
    chk("busy_prio_ratio", {24'd0, bus_a.div_ratio_rx}, 32'd1);
    rx_busy  = 1'b0;
    div_tick = 1'b0;
    step();
    chk("rewait_state", {30'd0, state_a}, {30'd0, ST_WTICK});
    do_gate(8'd8, 6'd4);

    // Timeout abort on the 16-cycle instance, with ignored requests while not ready
    do_reset();
    cfg_prescale = 6'd16;
    cfg_valid    = 1'b1;
    tx_busy      = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("to_ready", {31'd0, bus_b.cfg_ready}, 32'd0);
    for (int i = 1; i <= 15; i++) begin
      cfg_valid    = (i == 5) || (i == 9);
      cfg_prescale = (i == 5) ? 6'd12 : 6'd32;
      step();
      chk("to_no_err", {31'd0, bus_b.cfg_err}, 32'd0);
      chk("to_no_ack", {31'd0, bus_b.cfg_ack}, 32'd0);
      chk("to_hold_ready", {31'd0, bus_b.cfg_ready}, 32'd0);
    end
    cfg_valid = 1'b0;
    step();
    chk("to_err", {31'd0, bus_b.cfg_err}, 32'd1);
    chk("to_ack", {31'd0, bus_b.cfg_ack}, 32'd0);
    chk("to_ready_back", {31'd0, bus_b.cfg_ready}, 32'd1);
    chk("to_ratio", {24'd0, bus_b.div_ratio_rx}, 32'd1);
    chk("to_active", {26'd0, bus_b.active_prescale}, 32'd32);
    chk("to_en", {31'd0, bus_b.div_en}, 32'd1);
    chk("to_state", {30'd0, state_b}, {30'd0, ST_IDLE});
    step();
    chk("to_err_pulse", {31'd0, bus_b.cfg_err}, 32'd0);
    tx_busy = 1'b0;

    // Reset asserted inside the gate window
    do_reset();
    cfg_prescale = 6'd8;
    cfg_valid    = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    step();
    div_tick = 1'b1;
    step();
    div_tick = 1'b0;
    chk("g_rst_pre_en", {31'd0, bus_a.div_en}, 32'd0);
    chk("g_rst_pre_ratio", {24'd0, bus_a.div_ratio_rx}, 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("g_rst_en", {31'd0, bus_a.div_en}, 32'd1);
    chk("g_rst_ratio", {24'd0, bus_a.div_ratio_rx}, 32'd1);
    chk("g_rst_active", {26'd0, bus_a.active_prescale}, 32'd32);
    chk("g_rst_ready", {31'd0, bus_a.cfg_ready}, 32'd1);
    chk("g_rst_ack", {31'd0, bus_a.cfg_ack}, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_ack", {31'd0, bus_a.cfg_ack}, 32'd0);
      chk("post_rst_state", {30'd0, state_a}, {30'd0, ST_IDLE});
      chk("post_rst_en", {31'd0, bus_a.div_en}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
